// File: rtl/max7219_sched_pkg.sv
// max7219_sched_pkg: MAX7219 register addresses, scheduler state encoding and frame packing
package max7219_sched_pkg;
  localparam logic [3:0] REG_NOOP     = 4'h0;
  localparam logic [3:0] REG_DIGIT0   = 4'h1;
  localparam logic [3:0] REG_DECODE   = 4'h9;
  localparam logic [3:0] REG_INTENS   = 4'hA;
  localparam logic [3:0] REG_SCANLIM  = 4'hB;
  localparam logic [3:0] REG_SHUTDN   = 4'hC;
  localparam logic [3:0] REG_DISPTEST = 4'hF;
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  function automatic logic [15:0] mk_frame(input logic [3:0] r, input logic [7:0] d);
    return {4'h0, r, d};
  endfunction
endpackage

// File: rtl/max7219_sched_shift.sv
// max7219_shift: 16-bit MSB-first serializer, SCK low then high for SCK_DIV cycles per bit
module max7219_shift #(
  parameter int SCK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] frame,
  output logic        sck,
  output logic        din,
  output logic        done
);
  localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCK_DIV - 1);
  logic act_q, act_d, ph_q, ph_d, wrap;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [15:0] sr_q, sr_d;
  always_comb begin
    wrap = act_q && div_q == DIV_MAX;
    done = wrap && ph_q && bit_q == 4'd15;
    act_d = start || (act_q && !done);
    div_d = start || wrap ? '0 : act_q ? div_q + 1'b1 : div_q;
    ph_d = start ? 1'b0 : wrap ? ~ph_q : ph_q;
    bit_d = start ? '0 : wrap && ph_q ? bit_q + 4'd1 : bit_q;
    sr_d = start ? frame : wrap && ph_q ? {sr_q[14:0], 1'b0} : sr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      act_q <= 1'b0;
      ph_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
    end else begin
      act_q <= act_d;
      ph_q <= ph_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
    end
  end
  assign sck = act_q && ph_q;
  assign din = act_q && sr_q[15];
endmodule

// File: rtl/max7219_sched.sv
// max7219_sched: MAX7219 init sequencer and blank/intensity/digit-write arbiter onto one serial link
module max7219_sched
  import max7219_sched_pkg::*;
#(
  parameter int         SCK_DIV     = 2,
  parameter logic [7:0] DECODE_MODE = 8'hFF,
  parameter logic [2:0] SCAN_LIMIT  = 3'd7,
  parameter logic [3:0] INT_INIT    = 4'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [3:0] intensity,
  input  logic       blank,
  output logic       init_done,
  output logic       busy,
  output logic       max_sck,
  output logic       max_load,
  output logic       max_din
);
  localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCK_DIV - 1);
  logic [2:0] state_q, state_d, step_q, step_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic init_done_q, init_done_d, sent_blank_q, sent_blank_d;
  logic [3:0] sent_int_q, sent_int_d;
  logic start, sh_done, pend_b, pend_i, cnt_end;
  logic [15:0] frame;
  function automatic logic [15:0] init_frame(input logic [2:0] s);
    return s == 3'd0 ? mk_frame(REG_SHUTDN, 8'h00) :
           s == 3'd1 ? mk_frame(REG_DISPTEST, 8'h00) :
           s == 3'd2 ? mk_frame(REG_DECODE, DECODE_MODE) :
           s == 3'd3 ? mk_frame(REG_SCANLIM, {5'h0, SCAN_LIMIT}) :
           s == 3'd4 ? mk_frame(REG_INTENS, {4'h0, INT_INIT}) :
                       mk_frame(REG_SHUTDN, 8'h01);
  endfunction
  always_comb begin
    pend_b = blank != sent_blank_q;
    pend_i = intensity != sent_int_q;
    cnt_end = cnt_q == DIV_MAX;
    wr_ready = state_q == ST_IDLE && init_done_q && !pend_b && !pend_i;
    state_d = state_q;
    step_d = step_q;
    cnt_d = '0;
    init_done_d = init_done_q;
    sent_blank_d = sent_blank_q;
    sent_int_d = sent_int_q;
    start = 1'b0;
    frame = init_frame(step_q);
    case (state_q)
      ST_INIT: begin
        start = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_IDLE: begin
        start = pend_b || pend_i || (wr_valid && wr_ready);
        frame = pend_b ? mk_frame(REG_SHUTDN, {7'h0, ~blank}) :
                pend_i ? mk_frame(REG_INTENS, {4'h0, intensity}) :
                         mk_frame(REG_DIGIT0 + {1'b0, wr_addr}, wr_data);
        sent_blank_d = blank;
        sent_int_d = pend_b ? sent_int_q : intensity;
        state_d = start ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: state_d = sh_done ? ST_LATCH : ST_SHIFT;
      ST_LATCH: begin
        cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
        state_d = cnt_end ? ST_GAP : ST_LATCH;
      end
      ST_GAP: begin
        cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
        // the next init frame starts straight out of GAP so each init step costs exactly one frame
        start = cnt_end && !init_done_q && step_q != 3'd5;
        step_d = start ? step_q + 3'd1 : step_q;
        init_done_d = init_done_q || (cnt_end && step_q == 3'd5);
        frame = init_frame(step_q + 3'd1);
        state_d = !cnt_end ? ST_GAP : start ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      step_q <= '0;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      sent_blank_q <= 1'b0;
      sent_int_q <= INT_INIT;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      init_done_q <= init_done_d;
      sent_blank_q <= sent_blank_d;
      sent_int_q <= sent_int_d;
    end
  end
  max7219_shift #(.SCK_DIV(SCK_DIV)) u_shift (
    .clock(clock),
    .reset(reset),
    .start(start),
    .frame(frame),
    .sck(max_sck),
    .din(max_din),
    .done(sh_done)
  );
  assign max_load = state_q == ST_LATCH;
  assign busy = state_q != ST_IDLE;
  assign init_done = init_done_q;
endmodule
